// File: rtl/pc_sequencer.sv
// Next-address controller for the program counter: sequential, jump, branch,
// interrupt vector and interrupt return, plus the pending latch and epc.
module pc_sequencer #(
  parameter int              WIDTH      = 32,
  parameter logic [WIDTH-1:0] IRQ_VECTOR = WIDTH'(100)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] programCounter,
  input  logic             stall,
  input  logic             jump,
  input  logic [WIDTH-1:0] jumpTarget,
  input  logic             branch,
  input  logic [WIDTH-1:0] branchTarget,
  input  logic             irq,
  input  logic             eret,
  output logic [WIDTH-1:0] address,
  output logic [WIDTH-1:0] epc,
  output logic             inService,
  output logic             irqAck
);

  // state   | meaning
  // RUN     | normal execution, a pending interrupt is taken
  // HANDLER | inside the interrupt handler, no nesting, eret returns
  typedef enum logic {
    RUN     = 1'b0,
    HANDLER = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_pending;
  logic [WIDTH-1:0] r_epc;
  logic             r_irq_ack;

  logic [WIDTH-1:0] w_seq;
  logic [WIDTH-1:0] w_normal;
  logic [WIDTH-1:0] w_epc_next;
  logic             w_take;

  assign w_seq    = programCounter + WIDTH'(1);
  assign w_normal = jump ? jumpTarget : (branch ? branchTarget : w_seq);

  always_comb begin
    address      = w_normal;
    w_next_state = r_state;
    w_epc_next   = r_epc;
    w_take       = 1'b0;
    if (reset) begin
      address = '0;
    end else if (stall) begin
      address = programCounter;
    end else begin
      case (r_state)
        RUN: begin
          if (r_pending) begin
            w_take       = 1'b1;
            address      = IRQ_VECTOR;
            w_epc_next   = w_normal;
            w_next_state = HANDLER;
          end
        end
        HANDLER: begin
          if (eret) begin
            address      = r_epc;
            w_next_state = RUN;
          end
        end
        default: w_next_state = RUN;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= RUN;
      r_pending <= 1'b0;
      r_epc     <= '0;
      r_irq_ack <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      // an irq coincident with a take re-pends immediately
      r_pending <= (r_pending & ~w_take) | irq;
      r_epc     <= w_epc_next;
      r_irq_ack <= w_take;
    end
  end

  assign epc       = r_epc;
  assign inService = (r_state == HANDLER);
  assign irqAck    = r_irq_ack;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-address controller for the program counter register. Every cycle it selects the address the program counter loads on the next clock edge: sequential increment, jump, branch, interrupt vector or interrupt return. It owns the interrupt pending latch, the saved return address (epc) and the in-handler state. Its `address` output drives the program counter's `address` input directly.

## Interface
- `WIDTH`, 32, address width in bits (instruction-word addressing)
- `IRQ_VECTOR`, 100, handler entry address

- `clock`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high
- `programCounter`  in  WIDTH  current registered PC (instruction now executing)
- `stall`  in  1  hold PC; highest priority
- `jump`  in  1  take `jumpTarget`
- `jumpTarget`  in  WIDTH  absolute jump address
- `branch`  in  1  take `branchTarget`
- `branchTarget`  in  WIDTH  absolute branch address
- `irq`  in  1  interrupt request, one-cycle pulse per request
- `eret`  in  1  return from interrupt
- `address`  out  WIDTH  next PC (combinational)
- `epc`  out  WIDTH  saved return address (registered)
- `inService`  out  1  high while in handler (registered)
- `irqAck`  out  1  one-cycle pulse after interrupt entry (registered)

## Operation
- Reset: one clock, synchronous and active-high, named `clock` / `reset` as in the rest of the design.
- Registered state:
  - FSM state: RUN or HANDLER.
  - `pending`: 1-bit interrupt latch.
  - `epc`.
  - `irqAck`.
- `seq = programCounter + 1`, modulo 2^WIDTH (0xFFFFFFFF wraps to 0).
- `normal` = `jumpTarget` if `jump`, else `branchTarget` if `branch`, else `seq`. `jump` beats `branch` when both are asserted.
- While `reset`:
  - `address = 0`.
  - Next state: RUN, `pending = 0`, `epc = 0`, `irqAck = 0`, `inService = 0`.
- Stall (any state, not in reset):
  - `address = programCounter`.
  - State, `epc` and `pending` hold, except that `irq` is still latched into `pending`.
  - `jump`, `branch` and `eret` are ignored. Upstream holds them until `stall` drops.
- RUN, no stall:
  - `take = pending`.
  - If `take`: `address = IRQ_VECTOR`, `epc <= normal`, `inService` goes to HANDLER, `irqAck <= 1` for one cycle.
  - Else: `address = normal`.
  - `eret` in RUN is ignored and treated as `normal`.
- HANDLER, no stall:
  - If `eret`: `address = epc`, next state RUN. `eret` beats `jump` and `branch`.
  - Else: `address = normal`.
  - `pending` is not taken, so there is no nesting. `epc` holds.
- Pending update: `pending <= (pending & ~take) | irq`.
  - An `irq` arriving in the same cycle as a take re-pends.
  - A held-high `irq` re-pends every cycle. This is defined behaviour; the source must pulse `irq`.
- Interrupt pending at `eret`: return happens first. In the cycle after the return the returned-to instruction executes (RUN). The interrupt is taken in that cycle with `epc = normal` of that instruction. Net effect: at least one instruction runs between handlers.
- A reset asserted while in HANDLER returns to RUN and drops `pending` and `epc`.

## Timing
- `address` is purely combinational from inputs and registered state. The PC loads it at the next edge (one-cycle redirect latency).
- `irq` pulse in cycle n:
  - `pending = 1` in cycle n+1, which drives `address = IRQ_VECTOR`.
  - `programCounter = IRQ_VECTOR` and `inService = 1` from cycle n+2.
  - `irqAck = 1` in cycle n+2 only.
- `irq` pulse during stall: taken in the first non-stalled cycle.
- `eret` in HANDLER in cycle n: `programCounter = epc` and `inService = 0` from cycle n+1.
- Reset values: `epc = 0`, `inService = 0`, `irqAck = 0`, `address = 0` while `reset` is high.

## Test plan
- **Reset and increment:** `reset` 1 for 2 cycles with programCounter=25 -> `address=0`, `inService=0`, `irqAck=0`, `epc=0`. After release with programCounter=25 -> `address=26`. With programCounter=0xFFFFFFFF -> `address=0`.
- **Priority:** `jump`=1 (jumpTarget=40) and `branch`=1 (branchTarget=60) together, PC=10 -> `address=40`. `branch` alone -> `address=60`. Add `stall` -> `address=10`.
- **Interrupt entry and return:** `irq` pulse at PC=30 with `branch` to 70 asserted in the take cycle -> `address=100`, `epc=70`, `irqAck` high exactly one cycle, `inService=1`. Later `eret` -> `address=70`, `inService=0`.
- **No nesting, back-to-back interrupts:** `irq` pulse while in HANDLER -> no redirect. `eret` -> `address=epc`. In the next cycle with PC=epc -> `address=100` and `epc=old epc+1`.
- **Stall interaction:** `irq` pulse while `stall`=1 for 3 cycles -> `address=PC` throughout, `irqAck=0`. First unstalled cycle -> `address=100`. `eret` during stall -> ignored.
- **Reset mid-handler:** in HANDLER with `pending`=1, assert `reset` -> `inService=0`, `epc=0`. After release, no interrupt is taken without a new `irq`.
